// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and issue bundle between decode/writeback and regfile_mp
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD-1:0]        rd_en;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*XLEN-1:0]   rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  we0;
  logic [ADDR_W-1:0]     waddr0;
  logic [XLEN-1:0]       wdata0;
  logic                  we1;
  logic [ADDR_W-1:0]     waddr1;
  logic [XLEN-1:0]       wdata1;
  logic                  issue_en;
  logic [ADDR_W-1:0]     issue_addr;
  modport master (
    output rd_en, rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_en, issue_addr,
    input  rd_data, rd_busy
  );
  modport slave (
    input  rd_en, rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1, issue_en, issue_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, optional bypass and a busy scoreboard
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave rf
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NREGS-1:0]    busy_q, busy_d;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;
  logic [ADDR_W-1:0]   ra;
  logic                w0_ok, w1_ok, iss_ok;
  assign w0_ok  = rf.we0 && !(ZR && rf.waddr0 == '0);
  assign w1_ok  = rf.we1 && !(ZR && rf.waddr1 == '0);
  assign iss_ok = rf.issue_en && !(ZR && rf.issue_addr == '0);
  // port 1 is applied after port 0 so it wins; issue is applied last so set beats clear
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    if (w0_ok) begin
      regs_d[rf.waddr0] = rf.wdata0;
      busy_d[rf.waddr0] = 1'b0;
    end
    if (w1_ok) begin
      regs_d[rf.waddr1] = rf.wdata1;
      busy_d[rf.waddr1] = 1'b0;
    end
    if (iss_ok) busy_d[rf.issue_addr] = 1'b1;
    for (int i = 0; i < NRD; i++) begin
      ra = rf.rd_addr[i*ADDR_W +: ADDR_W];
      if (rf.rd_en[i]) begin
        rd_data_d[i*XLEN +: XLEN] = (ZR && ra == '0) ? '0 : BP ? regs_d[ra] : regs_q[ra];
        rd_busy_d[i]              = (ZR && ra == '0) ? 1'b0 : BP ? busy_d[ra] : busy_q[ra];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end
  assign rf.rd_data = rd_data_q;
  assign rf.rd_busy = rd_busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two builds (bypass+x0 hardwired, plain) driven in lockstep against a reference model
module tb_regfile_mp;
  localparam int XLEN = 32, AW = 5, NRD = 2, NREGS = 32;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [NRD-1:0]      rd_en = '0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic                we0 = 0, we1 = 0, issue_en = 0;
  logic [AW-1:0]       waddr0 = '0, waddr1 = '0, issue_addr = '0;
  logic [XLEN-1:0]     wdata0 = '0, wdata1 = '0;
  regfile_mp_if #(.XLEN(XLEN), .ADDR_W(AW), .NRD(NRD)) ifa ();
  regfile_mp_if #(.XLEN(XLEN), .ADDR_W(AW), .NRD(NRD)) ifb ();
  assign ifa.rd_en = rd_en;       assign ifb.rd_en = rd_en;
  assign ifa.rd_addr = rd_addr;   assign ifb.rd_addr = rd_addr;
  assign ifa.we0 = we0;           assign ifb.we0 = we0;
  assign ifa.waddr0 = waddr0;     assign ifb.waddr0 = waddr0;
  assign ifa.wdata0 = wdata0;     assign ifb.wdata0 = wdata0;
  assign ifa.we1 = we1;           assign ifb.we1 = we1;
  assign ifa.waddr1 = waddr1;     assign ifb.waddr1 = waddr1;
  assign ifa.wdata1 = wdata1;     assign ifb.wdata1 = wdata1;
  assign ifa.issue_en = issue_en; assign ifb.issue_en = issue_en;
  assign ifa.issue_addr = issue_addr; assign ifb.issue_addr = issue_addr;
  regfile_mp #(.XLEN(XLEN), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rf(ifa));
  regfile_mp #(.XLEN(XLEN), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rf(ifb));
  // model state: index 0 = build A (x0 hardwired, bypass), 1 = build B (plain)
  logic [XLEN-1:0]  m_regs [2][NREGS];
  logic [NREGS-1:0] m_busy [2];
  logic [XLEN-1:0]  m_rd   [2][NRD];
  logic             m_rb   [2][NRD];
  int total = 0, bad = 0;
  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < NREGS; r++) m_regs[c][r] = '0;
      m_busy[c] = '0;
      for (int p = 0; p < NRD; p++) begin m_rd[c][p] = '0; m_rb[c][p] = 0; end
    end
  endtask
  task automatic model_edge();
    logic [XLEN-1:0]  nr [NREGS];
    logic [NREGS-1:0] nb;
    bit zr, bp;
    int a;
    for (int c = 0; c < 2; c++) begin
      zr = (c == 0); bp = (c == 0);
      for (int r = 0; r < NREGS; r++) nr[r] = m_regs[c][r];
      nb = m_busy[c];
      if (we0 && !(zr && waddr0 == 0)) begin nr[waddr0] = wdata0; nb[waddr0] = 0; end
      if (we1 && !(zr && waddr1 == 0)) begin nr[waddr1] = wdata1; nb[waddr1] = 0; end
      if (issue_en && !(zr && issue_addr == 0)) nb[issue_addr] = 1;
      for (int p = 0; p < NRD; p++) if (rd_en[p]) begin
        a = int'(rd_addr[p*AW +: AW]);
        if (zr && a == 0) begin m_rd[c][p] = '0; m_rb[c][p] = 0; end
        else begin
          m_rd[c][p] = bp ? nr[a] : m_regs[c][a];
          m_rb[c][p] = bp ? nb[a] : m_busy[c][a];
        end
      end
      for (int r = 0; r < NREGS; r++) m_regs[c][r] = nr[r];
      m_busy[c] = nb;
    end
  endtask
  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("%s A.data%0d", tag, p), ifa.rd_data[p*XLEN +: XLEN], m_rd[0][p]);
      chk($sformatf("%s A.busy%0d", tag, p), XLEN'(ifa.rd_busy[p]), XLEN'(m_rb[0][p]));
      chk($sformatf("%s B.data%0d", tag, p), ifb.rd_data[p*XLEN +: XLEN], m_rd[1][p]);
      chk($sformatf("%s B.busy%0d", tag, p), XLEN'(ifb.rd_busy[p]), XLEN'(m_rb[1][p]));
    end
  endtask
  task automatic idle();
    rd_en = '0; we0 = 0; we1 = 0; issue_en = 0;
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
    idle();
  endtask
  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask
  initial begin
    model_reset();
    #12;
    chk_all("reset");
    reset = 0;
    // write x5 then read it on port 0
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    step("wr x5");
    rd(0, 5);
    step("rd x5");
    chk("x5 const", ifa.rd_data[31:0], 32'hDEADBEEF);
    // same-edge dual write to x7, port 1 wins
    we0 = 1; waddr0 = 7; wdata0 = 32'h11; we1 = 1; waddr1 = 7; wdata1 = 32'h22;
    step("dual wr x7");
    rd(0, 7); rd(1, 7);
    step("rd x7");
    chk("x7 const", ifb.rd_data[63:32], 32'h22);
    // read x3 on the same edge it is written
    we0 = 1; waddr0 = 3; wdata0 = 32'hA5A5; rd(0, 3);
    step("bypass x3");
    chk("bypass A", ifa.rd_data[31:0], 32'hA5A5);
    chk("nobypass B", ifb.rd_data[31:0], 32'h0);
    // writes and issues to x0
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF; issue_en = 1; issue_addr = 0;
    step("wr/iss x0");
    rd(1, 0);
    step("rd x0");
    chk("x0 A data", ifa.rd_data[63:32], 32'h0);
    chk("x0 A busy", XLEN'(ifa.rd_busy[1]), 32'h0);
    // scoreboard on x9
    issue_en = 1; issue_addr = 9;
    step("iss x9");
    rd(0, 9);
    step("rd x9 busy");
    chk("x9 busy", XLEN'(ifa.rd_busy[0]), 32'h1);
    we0 = 1; waddr0 = 9; wdata0 = 32'h5;
    step("wr x9");
    rd(0, 9);
    step("rd x9 clr");
    chk("x9 data", ifa.rd_data[31:0], 32'h5);
    chk("x9 clr", XLEN'(ifa.rd_busy[0]), 32'h0);
    we1 = 1; waddr1 = 9; wdata1 = 32'h6; issue_en = 1; issue_addr = 9; rd(1, 9);
    step("iss+wr x9");
    chk("x9 set wins", XLEN'(ifa.rd_busy[1]), 32'h1);
    // async reset mid-cycle with x4 loaded and busy
    we0 = 1; waddr0 = 4; wdata0 = 32'h1234; issue_en = 1; issue_addr = 4;
    step("load x4");
    rd(0, 4); rd(1, 4);
    step("rd x4");
    #2 reset = 1;
    #1;
    model_reset();
    chk_all("async reset");
    we0 = 1; waddr0 = 4; wdata0 = 32'h9999; issue_en = 1; issue_addr = 4; rd(0, 4);
    @(posedge clk);
    #1;
    chk_all("held reset");
    idle();
    #3 reset = 0;
    rd(0, 4); rd(1, 4);
    step("rd x4 after rst");
    chk("x4 zero", ifb.rd_data[31:0], 32'h0);
    // randomized traffic on a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      rd_en = NRD'($urandom);
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      we0 = 1'($urandom); waddr0 = AW'($urandom_range(0, 7)); wdata0 = $urandom;
      we1 = 1'($urandom); waddr1 = AW'($urandom_range(0, 7)); wdata1 = $urandom;
      issue_en = 1'($urandom); issue_addr = AW'($urandom_range(0, 7));
      step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
